// File: rtl/uart_rx_pkg.sv
// Shared constants and clamp helpers for the UART RX oversampling path.
package uart_rx_pkg;

    localparam int unsigned MIN_PRESCALE  = 6;
    localparam int unsigned MIN_FRAME_LEN = 2;
    localparam logic        IDLE_LEVEL    = 1'b1;

    // Odd ratios have no centre edge, so bit 0 is dropped before clamping.
    function automatic logic [31:0] eff_prescale(input logic [31:0] p);
        logic [31:0] even;
        even = p & ~32'd1;
        return (even < 32'(MIN_PRESCALE)) ? 32'(MIN_PRESCALE) : even;
    endfunction

    function automatic logic [31:0] eff_frame_len(input logic [31:0] l);
        return (l < 32'(MIN_FRAME_LEN)) ? 32'(MIN_FRAME_LEN) : l;
    endfunction

endpackage

// File: rtl/uart_rx_vote_sampler_if.sv
// Bundle between the RX FSM (master) and the oversampling vote sampler (slave).
interface uart_rx_vote_sampler_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
);
    // No backpressure: dat_samp_en is a level enable, and sample_valid /
    // frame_done are single-cycle strobes the master must take when they fire.
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic [BIT_CNT_W-1:0]  frame_len;
    logic                  dat_samp_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  sampled_bit;
    logic                  sample_valid;
    logic                  noise_err;
    logic                  frame_done;

    modport master (
        output rx_in, prescale, frame_len, dat_samp_en,
        input  edge_cnt, bit_cnt, sampled_bit, sample_valid, noise_err, frame_done
    );

    modport slave (
        input  rx_in, prescale, frame_len, dat_samp_en,
        output edge_cnt, bit_cnt, sampled_bit, sample_valid, noise_err, frame_done
    );
endinterface

// File: rtl/oversample_counter.sv
// Edge/bit position counter with prescale and frame length latched on enable rise.
module oversample_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic [BIT_CNT_W-1:0]  i_frame_len,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic [PRESCALE_W-1:0] o_period,
    output logic                  o_frame_done
);

    logic                  r_en_d;
    logic                  r_active;
    logic [PRESCALE_W-1:0] r_period;
    logic [BIT_CNT_W-1:0]  r_frame_len;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_frame_done;
    logic                  w_rise;
    logic                  w_edge_last;
    logic                  w_edge_penult;
    logic                  w_bit_last;

    assign w_rise        = i_en & ~r_en_d;
    assign w_edge_last   = (r_edge_cnt == r_period - PRESCALE_W'(1));
    assign w_edge_penult = (r_edge_cnt == r_period - PRESCALE_W'(2));
    assign w_bit_last    = (r_bit_cnt == r_frame_len - BIT_CNT_W'(1));

    // r_en_d resets high and r_active low so an enable already high at reset
    // release does not start counting; a fresh low-to-high transition is needed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_d       <= 1'b1;
            r_active     <= 1'b0;
            r_period     <= PRESCALE_W'(MIN_PRESCALE);
            r_frame_len  <= BIT_CNT_W'(MIN_FRAME_LEN);
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_en_d       <= i_en;
            r_frame_done <= 1'b0;
            if (!i_en) begin
                r_active   <= 1'b0;
                r_edge_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (w_rise) begin
                // The rise cycle itself is edge 0, so the next edge is 1.
                r_active    <= 1'b1;
                r_period    <= PRESCALE_W'(eff_prescale(32'(i_prescale)));
                r_frame_len <= BIT_CNT_W'(eff_frame_len(32'(i_frame_len)));
                r_edge_cnt  <= PRESCALE_W'(1);
                r_bit_cnt   <= '0;
            end else if (r_active) begin
                r_frame_done <= w_edge_penult & w_bit_last;
                if (w_edge_last) begin
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= w_bit_last ? '0 : r_bit_cnt + BIT_CNT_W'(1);
                end else begin
                    r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                end
            end
        end
    end

    assign o_edge_cnt   = r_edge_cnt;
    assign o_bit_cnt    = r_bit_cnt;
    assign o_period     = r_period;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/uart_rx_vote_sampler.sv
// UART RX bit sampler: rx_in synchroniser, oversample counter and 3-sample mid-bit vote.
module uart_rx_vote_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int BIT_CNT_W   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    uart_rx_vote_sampler_if.slave  io_bus
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic                   r_s0;
    logic                   r_s1;
    logic                   r_sampled_bit;
    logic                   r_sample_valid;
    logic                   r_noise_err;
    logic [PRESCALE_W-1:0]  w_period;
    logic [PRESCALE_W-1:0]  w_half;
    logic [PRESCALE_W-1:0]  w_edge_cnt;
    logic                   w_vote_lo;
    logic                   w_vote_mid;
    logic                   w_vote_hi;
    logic                   w_maj;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], io_bus.rx_in};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    oversample_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_cnt (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (io_bus.dat_samp_en),
        .i_prescale   (io_bus.prescale),
        .i_frame_len  (io_bus.frame_len),
        .o_edge_cnt   (w_edge_cnt),
        .o_bit_cnt    (io_bus.bit_cnt),
        .o_period     (w_period),
        .o_frame_done (io_bus.frame_done)
    );

    assign w_half     = w_period >> 1;
    assign w_vote_lo  = (w_edge_cnt == w_half - PRESCALE_W'(1));
    assign w_vote_mid = (w_edge_cnt == w_half);
    assign w_vote_hi  = (w_edge_cnt == w_half + PRESCALE_W'(1));
    // The third sample is the live synchronised line at edge P/2+1; the vote
    // result is registered on that same edge and appears at edge P/2+2.
    assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s0           <= 1'b0;
            r_s1           <= 1'b0;
            r_sampled_bit  <= IDLE_LEVEL;
            r_sample_valid <= 1'b0;
            r_noise_err    <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_noise_err    <= 1'b0;
            if (!io_bus.dat_samp_en) begin
                r_s0 <= 1'b0;
                r_s1 <= 1'b0;
            end else begin
                if (w_vote_lo) r_s0 <= w_rx_s;
                if (w_vote_mid) r_s1 <= w_rx_s;
                if (w_vote_hi) begin
                    r_sampled_bit  <= w_maj;
                    r_sample_valid <= 1'b1;
                    r_noise_err    <= !((r_s0 == r_s1) && (r_s1 == w_rx_s));
                end
            end
        end
    end

    assign io_bus.edge_cnt     = w_edge_cnt;
    assign io_bus.sampled_bit  = r_sampled_bit;
    assign io_bus.sample_valid = r_sample_valid;
    assign io_bus.noise_err    = r_noise_err;

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Bench for uart_rx_vote_sampler: per-cycle reference model plus directed and random steps.
module tb_uart_rx_vote_sampler;

    localparam int PW = 6;
    localparam int BW = 4;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_rx_vote_sampler_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

    uart_rx_vote_sampler #(
        .PRESCALE_W  (PW),
        .BIT_CNT_W   (BW),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    // Drive values and reference model state
    logic       drv_rst_n = 1'b0;
    int         drv_prescale = 16;
    int         drv_frame_len = 10;
    int         cyc = -1;
    logic       rx_hist[$];
    logic       rst_prev = 1'b0;
    logic       en_prev_eff = 1'b1;
    int         run_t0 = -1;
    int         run_p = 6;
    int         run_l = 2;
    logic       exp_sampled = 1'b1;

    // Observation bookkeeping for directed checks
    int          strobe_cnt = 0;
    int          fd_cnt = 0;
    int          noise_cnt = 0;
    int          coin_cnt = 0;
    int          last_strobe_cyc = -1000;
    int          strobe_gap = 0;
    logic        obs_bit = 1'b0;
    logic        obs_noise = 1'b0;
    logic [15:0] obs_seq = '0;

    function automatic int eff_p(input int p);
        int e;
        e = p - (p % 2);
        return (e < 6) ? 6 : e;
    endfunction

    function automatic int eff_l(input int l);
        return (l < 2) ? 2 : l;
    endfunction

    function automatic int rx_s_at(input int c);
        int i;
        i = c - SS;
        return (i < 0) ? 1 : int'(rx_hist[i]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_and_check(input logic en);
        int   k;
        int   a, b, d;
        int   exp_edge, exp_bit;
        logic exp_valid, exp_noise, exp_fd;
        exp_edge = 0; exp_bit = 0;
        exp_valid = 1'b0; exp_noise = 1'b0; exp_fd = 1'b0;
        if (!drv_rst_n || !rst_prev) begin
            run_t0 = -1;
            exp_sampled = 1'b1;
        end else begin
            if (!en_prev_eff) run_t0 = -1;
            if (en && !en_prev_eff) begin
                run_t0 = cyc;
                run_p = eff_p(drv_prescale);
                run_l = eff_l(drv_frame_len);
            end
            if (run_t0 >= 0) begin
                k = cyc - run_t0;
                exp_edge = k % run_p;
                exp_bit = (k / run_p) % run_l;
                exp_fd = ((k % (run_p * run_l)) == run_p * run_l - 1);
                if (exp_edge == run_p / 2 + 2) begin
                    a = rx_s_at(cyc - 3);
                    b = rx_s_at(cyc - 2);
                    d = rx_s_at(cyc - 1);
                    exp_valid = 1'b1;
                    exp_sampled = ((a + b + d) >= 2);
                    exp_noise = !((a == b) && (b == d));
                end
            end
        end
        en_prev_eff = drv_rst_n ? en : 1'b1;
        rst_prev = drv_rst_n;

        check("edge_cnt", 32'(bus.edge_cnt), exp_edge);
        check("bit_cnt", 32'(bus.bit_cnt), exp_bit);
        check("sample_valid", 32'(bus.sample_valid), 32'(exp_valid));
        check("noise_err", 32'(bus.noise_err), 32'(exp_noise));
        check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
        check("sampled_bit", 32'(bus.sampled_bit), 32'(exp_sampled));

        if (bus.sample_valid === 1'b1) begin
            if (strobe_cnt < 16) obs_seq[strobe_cnt] = bus.sampled_bit;
            strobe_cnt++;
            strobe_gap = cyc - last_strobe_cyc;
            last_strobe_cyc = cyc;
            obs_bit = bus.sampled_bit;
            obs_noise = bus.noise_err;
            if (bus.noise_err === 1'b1) noise_cnt++;
        end
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            if (bus.sample_valid === 1'b1) coin_cnt++;
        end
    endtask

    task automatic step_cycle(input logic rx, input logic en);
        @(posedge clk);
        #1;
        cyc++;
        rx_hist.push_back(drv_rst_n ? rx : 1'b1);
        rst_n = drv_rst_n;
        bus.rx_in = rx;
        bus.dat_samp_en = en;
        bus.prescale = PW'(drv_prescale);
        bus.frame_len = BW'(drv_frame_len);
        @(negedge clk);
        model_and_check(en);
    endtask

    task automatic drive_bit(input logic v, input int p, input logic [63:0] glitch);
        for (int j = 0; j < p; j++) step_cycle(v ^ glitch[j], 1'b1);
    endtask

    task automatic drive_idle(input int n);
        for (int j = 0; j < n; j++) step_cycle(1'b1, 1'b0);
    endtask

    task automatic clear_obs();
        strobe_cnt = 0; fd_cnt = 0; noise_cnt = 0; coin_cnt = 0;
        obs_seq = '0; last_strobe_cyc = -1000;
    endtask

    initial begin
        logic [9:0]  frame55;
        logic [63:0] g;
        int          t_start;
        int          p_r, l_r, n_r;

        bus.rx_in = 1'b1;
        bus.dat_samp_en = 1'b0;
        bus.prescale = PW'(16);
        bus.frame_len = BW'(10);

        // Reset held with rx toggling and enable high
        drv_rst_n = 1'b0;
        for (int i = 0; i < 6; i++) step_cycle(i[0], 1'b1);
        check("rst_sampled_bit", 32'(bus.sampled_bit), 1);
        check("rst_sample_valid", 32'(bus.sample_valid), 0);
        drv_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step_cycle(1'b1, 1'b1);
        check("post_rst_edge_cnt", 32'(bus.edge_cnt), 0);
        check("post_rst_bit_cnt", 32'(bus.bit_cnt), 0);
        drive_idle(2);

        // P=16, L=10, frame 0x55 with start and stop bits
        drv_prescale = 16; drv_frame_len = 10;
        clear_obs();
        frame55 = {1'b1, 8'h55, 1'b0};
        t_start = cyc + 1;
        for (int i = 0; i < 10; i++) drive_bit(frame55[i], 16, 64'd0);
        check("f55_strobes", strobe_cnt, 10);
        check("f55_bits", 32'(obs_seq[9:0]), 32'(10'b1010101010));
        check("f55_frame_done", fd_cnt, 1);
        check("f55_noise", noise_cnt, 0);
        check("f55_last_strobe_time", last_strobe_cyc - t_start, 9 * 16 + 10);
        drive_idle(3);

        // P=8 glitches on the vote window of 1-bits
        drv_prescale = 8;
        drive_bit(1'b0, 8, 64'd0);
        drive_bit(1'b1, 8, 64'd1 << (8 / 2 - SS));
        check("glitch1_bit", 32'(obs_bit), 1);
        check("glitch1_noise", 32'(obs_noise), 1);
        drive_bit(1'b1, 8, (64'd1 << (8 / 2 - SS)) | (64'd1 << (8 / 2 - 1 - SS)));
        check("glitch2_bit", 32'(obs_bit), 0);
        check("glitch2_noise", 32'(obs_noise), 1);
        drive_bit(1'b1, 8, 64'd0);
        check("clean_bit", 32'(obs_bit), 1);
        check("clean_noise", 32'(obs_noise), 0);
        drive_idle(2);

        // Clamping of prescale and frame length
        drv_prescale = 5;
        for (int i = 0; i < 3; i++) drive_bit(i[0], 6, 64'd0);
        check("clamp_p5_gap", strobe_gap, 6);
        drive_idle(2);
        drv_prescale = 17;
        for (int i = 0; i < 3; i++) drive_bit(i[0], 16, 64'd0);
        check("clamp_p17_gap", strobe_gap, 16);
        drive_idle(2);
        drv_prescale = 6; drv_frame_len = 1;
        clear_obs();
        for (int i = 0; i < 4; i++) drive_bit(i[0], 6, 64'd0);
        check("clamp_l1_frames", fd_cnt, 2);
        check("p6_coincide", coin_cnt, 2);
        drive_idle(2);

        // Prescale change while enabled is ignored until re-enable
        drv_prescale = 16; drv_frame_len = 10;
        drive_bit(1'b0, 16, 64'd0);
        drive_bit(1'b1, 16, 64'd0);
        drv_prescale = 32;
        drive_bit(1'b0, 16, 64'd0);
        drive_bit(1'b1, 16, 64'd0);
        check("pchg_old_gap", strobe_gap, 16);
        drive_idle(1);
        for (int i = 0; i < 3; i++) drive_bit(i[0], 32, 64'd0);
        check("pchg_new_gap", strobe_gap, 32);
        drive_idle(2);

        // Enable dropped at edge 5 of bit 3
        drv_prescale = 16;
        clear_obs();
        drive_bit(1'b0, 16, 64'd0);
        drive_bit(1'b1, 16, 64'd0);
        drive_bit(1'b1, 16, 64'd0);
        for (int j = 0; j < 5; j++) step_cycle(1'b0, 1'b1);
        check("drop_edge_before", 32'(bus.edge_cnt), 4);
        step_cycle(1'b0, 1'b0);
        step_cycle(1'b1, 1'b0);
        check("drop_edge_after", 32'(bus.edge_cnt), 0);
        check("drop_bit_after", 32'(bus.bit_cnt), 0);
        drive_idle(4);
        check("drop_strobes", strobe_cnt, 3);
        check("drop_hold_bit", 32'(bus.sampled_bit), 1);
        drive_bit(1'b0, 16, 64'd0);
        check("restart_bit", 32'(obs_bit), 0);
        check("restart_strobes", strobe_cnt, 4);
        drive_idle(2);

        // Reset asserted mid-frame with enable held high
        drive_bit(1'b0, 16, 64'd0);
        for (int j = 0; j < 7; j++) step_cycle(1'b1, 1'b1);
        drv_rst_n = 1'b0;
        step_cycle(1'b0, 1'b1);
        check("midrst_edge", 32'(bus.edge_cnt), 0);
        check("midrst_sampled", 32'(bus.sampled_bit), 1);
        step_cycle(1'b0, 1'b1);
        drv_rst_n = 1'b1;
        for (int j = 0; j < 20; j++) step_cycle(1'b1, 1'b1);
        check("midrst_hold_edge", 32'(bus.edge_cnt), 0);
        drive_idle(2);

        // Random frames, ratios, lengths and glitches
        for (int f = 0; f < 8; f++) begin
            p_r = $urandom_range(0, 63);
            l_r = $urandom_range(0, 15);
            n_r = $urandom_range(1, eff_l(l_r) + 3);
            drv_prescale = p_r; drv_frame_len = l_r;
            for (int i = 0; i < n_r; i++) begin
                g = ($urandom_range(0, 2) == 0) ? (64'd1 << $urandom_range(0, eff_p(p_r) - 1)) : 64'd0;
                drive_bit(1'($urandom_range(0, 1)), eff_p(p_r), g);
            end
            for (int j = 0; j < $urandom_range(0, eff_p(p_r) - 1); j++) step_cycle(1'($urandom_range(0, 1)), 1'b1);
            drive_idle($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_vote_sampler.md
# uart_rx_vote_sampler

Parametrised oversampling bit sampler for the UART receive path, replacing the fixed-ratio sampler and its separate edge/bit counter. Resynchronises `rx_in`, counts oversampling edges and bit positions under a runtime-programmable prescale, takes a 3-sample majority vote around mid-bit, and emits one `sample_valid` strobe per bit with a noise flag. Sits between the RX pin and the RX FSM / deserializer / parity and stop checkers.

## Interface
- `PRESCALE_W`, 6: width of `prescale` and `edge_cnt`; maximum prescale is 2^PRESCALE_W-2.
- `BIT_CNT_W`, 4: width of `frame_len` and `bit_cnt`.
- `SYNC_STAGES`, 2: flops in the `rx_in` synchroniser; legal values are 2 to 4.

- `clk`, in, 1: oversampling clock; the single clock domain.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx_in`, in, 1: asynchronous serial line, idle high.
- `prescale`, in, PRESCALE_W: oversampling ratio; latched only on a rising edge of `dat_samp_en`.
- `frame_len`, in, BIT_CNT_W: bits per frame including start, parity and stop; latched together with `prescale`.
- `dat_samp_en`, in, 1: level enable from the RX FSM; while high, counting and sampling run.
- `edge_cnt`, out, PRESCALE_W: edge position within the current bit, 0 to P-1.
- `bit_cnt`, out, BIT_CNT_W: bit index within the frame, 0 to L-1.
- `sampled_bit`, out, 1: majority-voted value of the last bit; holds between strobes.
- `sample_valid`, out, 1: one-cycle strobe; `sampled_bit` is new this cycle.
- `noise_err`, out, 1: qualified by `sample_valid`; high when the three samples disagree.
- `frame_done`, out, 1: one-cycle strobe on the last edge of bit L-1.

## Operation
- Effective prescale P:
  - Computed at latch time as `prescale` with bit 0 cleared (forced even).
  - Values below 6 are clamped to 6 (the shared constant MIN_PRESCALE).
- Effective frame length L: `frame_len`, with 0 and 1 clamped to 2.
- Synchroniser: `SYNC_STAGES` flops on `rx_in`, reset to 1. All sampling uses the synchronised value `rx_s`.
- Rising edge of `dat_samp_en` (registered compare):
  - Latch P and L.
  - `edge_cnt` and `bit_cnt` start at 0 in that cycle.
- While `dat_samp_en` is high:
  - `edge_cnt` increments every cycle.
  - At P-1, `edge_cnt` wraps to 0 and `bit_cnt` increments.
  - At `bit_cnt`=L-1 with `edge_cnt`=P-1: assert `frame_done`, `bit_cnt` wraps to 0, and counting continues (back-to-back frames).
- Vote window: `rx_s` is captured into s0, s1, s2 at `edge_cnt` = P/2-1, P/2, P/2+1.
- In the cycle after s2 is captured (`edge_cnt` = P/2+2):
  - `sampled_bit` is updated to maj(s0,s1,s2).
  - `sample_valid` is asserted.
  - `noise_err` is set to !(s0==s1==s2).
- `dat_samp_en` low:
  - Counters and s0..s2 clear synchronously to 0; no strobes.
  - `sampled_bit` holds its value.
  - Dropping the enable mid-bit aborts that bit silently, with no `sample_valid`.
- Simultaneous events:
  - When P=6, `sample_valid` (edge 5) and the wrap coincide; both take effect.
  - On the last bit, `frame_done` and that bit's `sample_valid` are separate cycles unless P=6, in which case they coincide.
- `prescale` and `frame_len` changes while enabled are ignored until the next enable rising edge.

## Timing
- Reset values:
  - `sampled_bit`=1.
  - `edge_cnt`, `bit_cnt`, `sample_valid`, `noise_err`, `frame_done` = 0.
  - Synchroniser = all 1s.
- `rx_in` to `rx_s` latency: SYNC_STAGES cycles.
- `sample_valid` occurs P/2+2 cycles after each bit's `edge_cnt`=0.
- Exactly one `sample_valid` per completed bit period, and L per frame.
- All outputs are registered; no combinational path from input to output.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, counting waits for a fresh enable rising edge, even if `dat_samp_en` is already high.

## Structure
- Package `uart_rx_pkg`:
  - MIN_PRESCALE=6, MIN_FRAME_LEN=2, IDLE_LEVEL=1'b1.
  - Function `eff_prescale()` that clamps and forces even.
- Sub-module `oversample_counter`: holds the P/L latch, `edge_cnt`, `bit_cnt` and `frame_done`. It is reusable by the TX baud generator.
- The top level contains the synchroniser, vote registers and output flops.

## Test plan
- Reset: hold `rst`=0 with `rx_in` toggling → `sampled_bit`=1 and all other outputs 0. After release with `dat_samp_en`=1 already high, counters stay 0.
- P=16, L=10, frame 0x55 (LSB first, start 0, stop 1) → 10 strobes, each 10 cycles after bit start, carrying bits 0,1,0,1,0,1,0,1,0,1. `frame_done` after 160 cycles. `noise_err`=0 throughout.
- P=8: one-cycle glitch on the centre sample of a 1-bit → `sampled_bit`=1 and `noise_err`=1. Glitch on two samples → `sampled_bit`=0 and `noise_err`=1.
- Clamping: `prescale`=5 → bit period 6 cycles. `prescale`=17 → 16. `frame_len`=1 → `frame_done` every 2 bits.
- Change `prescale` 16→32 mid-frame → period stays 16 until `dat_samp_en` toggles low/high, then becomes 32.
- Drop `dat_samp_en` at `edge_cnt`=5, `bit_cnt`=3 → no strobe, counters 0 next cycle, `sampled_bit` holds. Re-enable gives a clean restart at bit 0.
